// File: rtl/trigger_pkg.sv
// Shared definitions for the trigger detector: FSM state encoding and the
// trigger source / edge selector values.
package trigger_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRETRIG  = 2'd1,
    ST_ARMED    = 2'd2,
    ST_POSTTRIG = 2'd3
  } state_t;

  localparam logic TRIG_SRC_LEVEL = 1'b0;
  localparam logic TRIG_SRC_EXT   = 1'b1;

  localparam logic EDGE_RISING  = 1'b0;
  localparam logic EDGE_FALLING = 1'b1;

endpackage

// File: rtl/trigger_comparator.sv
// Threshold crossing detector: flags a rising or falling crossing of an
// unsigned threshold between the previous and the current sample.
module trigger_comparator
  import trigger_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] prev_i,
  input  logic [DATA_WIDTH-1:0] cur_i,
  input  logic [DATA_WIDTH-1:0] thresh_i,
  input  logic                  edge_i,
  output logic                  event_o
);

  logic w_rise;
  logic w_fall;

  assign w_rise  = (prev_i < thresh_i) && (cur_i >= thresh_i);
  assign w_fall  = (prev_i > thresh_i) && (cur_i <= thresh_i);
  assign event_o = (edge_i == EDGE_FALLING) ? w_fall : w_rise;

endmodule

// File: rtl/trigger_detector.sv
// Acquisition trigger: forwards samples through a one-deep output register,
// counts a pretrigger window, detects a threshold/external trigger, then
// forwards the post-trigger window and pulses done.
module trigger_detector
  import trigger_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_rdy,
  output logic                   in_ack,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_rdy,
  input  logic                   out_ack,
  input  logic                   start,
  input  logic                   trigger_source,
  input  logic                   trigger_edge,
  input  logic [DATA_WIDTH-1:0]  trigger_value,
  input  logic                   ext_trigger,
  input  logic [COUNT_WIDTH-1:0] pretrigger,
  input  logic [COUNT_WIDTH-1:0] num_samples,
  output logic                   trigger_o,
  output logic                   busy,
  output logic                   done_o
);

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  state_t                 r_state;
  state_t                 w_state_next;

  logic                   r_src;
  logic                   r_edge;
  logic [DATA_WIDTH-1:0]  r_thr;
  logic [COUNT_WIDTH-1:0] r_pre;
  logic [COUNT_WIDTH-1:0] r_num;

  logic [COUNT_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0]  r_prev;
  logic                   r_prev_valid;
  logic                   r_pending;
  logic                   r_ext_prev;

  logic [DATA_WIDTH-1:0]  r_out_data;
  logic                   r_out_rdy;
  logic                   r_trig;
  logic                   r_done;

  logic                   w_accept;
  logic                   w_work;
  logic                   w_cmp_event;
  logic                   w_hit;
  logic                   w_ext_rise;
  logic                   w_fire;
  logic                   w_last;
  logic [COUNT_WIDTH-1:0] w_post_load;
  logic [COUNT_WIDTH-1:0] w_cnt_inc;

  // Samples are swallowed in IDLE; otherwise the output register must be free.
  assign in_ack   = (r_state == ST_IDLE) ? in_rdy : (in_rdy & (~r_out_rdy | out_ack));
  assign w_accept = in_rdy & in_ack;
  assign w_work   = w_accept && (r_state != ST_IDLE);

  assign out_data  = r_out_data;
  assign out_rdy   = r_out_rdy;
  assign trigger_o = r_trig;
  assign done_o    = r_done;
  assign busy      = (r_state != ST_IDLE);

  trigger_comparator #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_cmp (
    .prev_i   (r_prev),
    .cur_i    (in_data),
    .thresh_i (r_thr),
    .edge_i   (r_edge),
    .event_o  (w_cmp_event)
  );

  assign w_ext_rise  = ext_trigger & ~r_ext_prev;
  assign w_hit       = (r_src == TRIG_SRC_EXT) ? r_pending : (r_prev_valid & w_cmp_event);
  assign w_post_load = (r_num > r_pre) ? (r_num - r_pre) : CNT_ONE;
  assign w_cnt_inc   = r_cnt + CNT_ONE;

  always_ff @(posedge clk_i) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_fire       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = (pretrigger == '0) ? ST_ARMED : ST_PRETRIG;
        end
      end
      ST_PRETRIG: begin
        if (w_accept && (w_cnt_inc == r_pre)) begin
          w_state_next = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (w_accept && w_hit) begin
          w_fire = 1'b1;
          // A one-sample post window ends on the trigger sample itself.
          if (w_post_load == CNT_ONE) begin
            w_last       = 1'b1;
            w_state_next = ST_IDLE;
          end else begin
            w_state_next = ST_POSTTRIG;
          end
        end
      end
      ST_POSTTRIG: begin
        if (w_accept && (r_cnt == CNT_ONE)) begin
          w_last       = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      r_src        <= TRIG_SRC_LEVEL;
      r_edge       <= EDGE_RISING;
      r_thr        <= '0;
      r_pre        <= '0;
      r_num        <= '0;
      r_cnt        <= '0;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_pending    <= 1'b0;
      r_ext_prev   <= 1'b0;
      r_out_data   <= '0;
      r_out_rdy    <= 1'b0;
      r_trig       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_ext_prev <= ext_trigger;
      r_trig     <= w_fire;
      r_done     <= w_last;

      if (w_work) begin
        r_out_data   <= in_data;
        r_out_rdy    <= 1'b1;
        r_prev       <= in_data;
        r_prev_valid <= 1'b1;
      end else if (out_ack) begin
        r_out_rdy <= 1'b0;
      end

      if ((r_state == ST_IDLE) && start) begin
        r_src        <= trigger_source;
        r_edge       <= trigger_edge;
        r_thr        <= trigger_value;
        r_pre        <= pretrigger;
        r_num        <= num_samples;
        r_cnt        <= '0;
        r_prev_valid <= 1'b0;
        r_pending    <= 1'b0;
      end

      if ((r_state == ST_PRETRIG) && w_accept) begin
        r_cnt <= w_cnt_inc;
      end

      if (w_fire) begin
        r_cnt     <= w_post_load - CNT_ONE;
        r_pending <= 1'b0;
      end else if ((r_state == ST_ARMED) && w_ext_rise) begin
        r_pending <= 1'b1;
      end

      if ((r_state == ST_POSTTRIG) && w_accept && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_ONE;
      end
    end
  end

endmodule
